// File: rtl/gate_vec_pkg.sv
// Shared definitions for the gate-vector interface: legal code words,
// bit positions of each gate inside the 7-bit vector, and the decoder FSM states.
package gate_vec_pkg;

   // Bit positions of the gate outputs inside the 7-bit gate vector
   localparam int GATE_OR   = 0;
   localparam int GATE_AND  = 1;
   localparam int GATE_XOR  = 2;
   localparam int GATE_XNOR = 3;
   localparam int GATE_NAND = 4;
   localparam int GATE_NOR  = 5;
   localparam int GATE_SUM  = 6;

   localparam int GATE_VEC_W = 7;

   // The only three words a healthy two-input gate block can produce
   localparam logic [GATE_VEC_W-1:0] CODE_ZERO = 7'h38;  // a=0, b=0
   localparam logic [GATE_VEC_W-1:0] CODE_ONE  = 7'h55;  // a!=b
   localparam logic [GATE_VEC_W-1:0] CODE_TWO  = 7'h0B;  // a=1, b=1

   // Decoded value reported for any word outside the legal set
   localparam logic [1:0] ONES_INVALID = 2'b11;

   // Width of the saturating consecutive-error counter
   localparam int ERR_CNT_W = 4;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } dec_state_e;

   // Reference encoder: builds the gate vector for inputs a and b from the
   // individual gate equations. Handy for future checkers and documents how
   // the three legal codes arise.
   function automatic logic [GATE_VEC_W-1:0] gate_vec_encode(input logic a, input logic b);
      logic [GATE_VEC_W-1:0] v;
      v            = '0;
      v[GATE_OR]   = a | b;
      v[GATE_AND]  = a & b;
      v[GATE_XOR]  = a ^ b;
      v[GATE_XNOR] = ~(a ^ b);
      v[GATE_NAND] = ~(a & b);
      v[GATE_NOR]  = ~(a | b);
      v[GATE_SUM]  = a ^ b;
      return v;
   endfunction

endpackage

// File: rtl/gate_code_lookup.sv
// Pure combinational map from a 7-bit gate vector to the number of asserted
// gate inputs. Anything outside the three legal words is reported as
// ones=2'b11 with err=1.
module gate_code_lookup
   import gate_vec_pkg::*;
(
   input  logic [GATE_VEC_W-1:0] code_i,
   output logic [1:0]            ones_o,
   output logic                  err_o
);

   // Decode one gate vector; the default arm catches every illegal word
   always_comb begin
      ones_o = ONES_INVALID;
      err_o  = 1'b1;
      case (code_i)
         CODE_ZERO: begin
            ones_o = 2'd0;
            err_o  = 1'b0;
         end
         CODE_ONE: begin
            ones_o = 2'd1;
            err_o  = 1'b0;
         end
         CODE_TWO: begin
            ones_o = 2'd2;
            err_o  = 1'b0;
         end
         default: begin
            ones_o = ONES_INVALID;
            err_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/gate_vector_decoder.sv
// Streaming decoder for gate-vector words with a single output register
// stage, valid/ready on both sides and a latched FAULT state after
// ERR_LIMIT consecutive invalid words (legal range 1..15).
// Optional feature: define GATE_DEC_STATS_EN to add saturating per-class
// transfer counters cnt_zero/cnt_one/cnt_two/cnt_err (CNT_W bits each).
module gate_vector_decoder
   import gate_vec_pkg::*;
#(
   parameter int ERR_LIMIT = 3
`ifdef GATE_DEC_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [GATE_VEC_W-1:0] in_y,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            out_ones,
   output logic                  out_err,
   output logic                  fault,
   input  logic                  clear_fault
`ifdef GATE_DEC_STATS_EN
   ,
   output logic [CNT_W-1:0]      cnt_zero,
   output logic [CNT_W-1:0]      cnt_one,
   output logic [CNT_W-1:0]      cnt_two,
   output logic [CNT_W-1:0]      cnt_err
`endif
);

   localparam logic [ERR_CNT_W-1:0] ERR_LIMIT_C = ERR_CNT_W'(ERR_LIMIT);
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   dec_state_e            state_q;
   logic                  fault_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q;
   logic [ERR_CNT_W-1:0]  err_cnt_d;

   logic                  out_valid_q;
   logic [1:0]            out_ones_q;
   logic                  out_err_q;

   logic [1:0]            lk_ones;
   logic                  lk_err;
   logic                  xfer;

   gate_code_lookup u_lookup (
      .code_i (in_y),
      .ones_o (lk_ones),
      .err_o  (lk_err)
   );

   // Accept only in RUN and only when the output register is free or being
   // drained this same cycle; deliberately independent of in_valid
   always_comb begin
      in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
   end

   assign xfer = in_valid && in_ready;

   // Saturating increment of the consecutive-error count for an invalid word
   always_comb begin
      err_cnt_d = (err_cnt_q == ERR_CNT_MAX) ? ERR_CNT_MAX : err_cnt_q + 4'd1;
   end

   // Run/fault FSM with the consecutive-error counter and registered fault flag.
   // A clear_fault pulse takes priority over a same-cycle transfer for the
   // counter, so a clear is never undone by the word arriving alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         fault_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (clear_fault) begin
                  err_cnt_q <= '0;
               end else if (xfer) begin
                  if (lk_err) begin
                     err_cnt_q <= err_cnt_d;
                     if (err_cnt_d >= ERR_LIMIT_C) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                     end
                  end else begin
                     err_cnt_q <= '0;
                  end
               end
            end
            FAULT: begin
               if (clear_fault) begin
                  state_q   <= RUN;
                  fault_q   <= 1'b0;
                  err_cnt_q <= '0;
               end
            end
            default: begin
               state_q   <= RUN;
               fault_q   <= 1'b0;
               err_cnt_q <= '0;
            end
         endcase
      end
   end

   // Output register: load on every transfer, otherwise empty once consumed.
   // A pending result keeps draining even while the FSM sits in FAULT.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_ones_q  <= 2'd0;
         out_err_q   <= 1'b0;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_ones_q  <= lk_ones;
         out_err_q   <= lk_err;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ones  = out_ones_q;
   assign out_err   = out_err_q;
   assign fault     = fault_q;

`ifdef GATE_DEC_STATS_EN
   // One saturating counter per decoded class; the class index is the
   // decoded ones value itself (0, 1, 2, and 3 for invalid words).
   localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

   for (genvar gi = 0; gi < 4; gi++) begin : g_stat
      logic [CNT_W-1:0] cnt_q;

      // Count transfers of this class, holding at all-ones; only rst clears
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (xfer && (lk_ones == 2'(gi)) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_INC;
         end
      end
   end

   assign cnt_zero = g_stat[0].cnt_q;
   assign cnt_one  = g_stat[1].cnt_q;
   assign cnt_two  = g_stat[2].cnt_q;
   assign cnt_err  = g_stat[3].cnt_q;
`endif

endmodule

// File: tb/tb_gate_vector_decoder.sv
// Directed self-checking bench for gate_vector_decoder (ERR_LIMIT=3).
// The statistics scenario is built only when GATE_DEC_STATS_EN is defined.
module tb_gate_vector_decoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_y;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_ones;
   logic       out_err;
   logic       fault;
   logic       clear_fault;
`ifdef GATE_DEC_STATS_EN
   logic [15:0] cnt_zero;
   logic [15:0] cnt_one;
   logic [15:0] cnt_two;
   logic [15:0] cnt_err;
`endif

   int tests_run;
   int tests_failed;

   // Observed status word: {out_valid, out_ones[1:0], out_err, fault, in_ready}
   logic [5:0] obs;
   assign obs = {out_valid, out_ones, out_err, fault, in_ready};

   gate_vector_decoder #(
      .ERR_LIMIT (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_y        (in_y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ones    (out_ones),
      .out_err     (out_err),
      .fault       (fault),
      .clear_fault (clear_fault)
`ifdef GATE_DEC_STATS_EN
      ,
      .cnt_zero    (cnt_zero),
      .cnt_one     (cnt_one),
      .cnt_two     (cnt_two),
      .cnt_err     (cnt_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One line per accepted word, sampled half a cycle before the accepting edge
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready)
         $display("[TB] t=%0t accept in_y=%h", $time, in_y);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_y = 7'h00; out_ready = 1'b0; clear_fault = 1'b0;
      step(); step();
      rst = 1'b0;
      tests_run++;
      if (obs !== 6'b0_00_0_0_1) begin
         tests_failed++;
         $display("FAIL reset_state got=%b exp=%b", obs, 6'b0_00_0_0_1);
      end
      step();
      tests_run++;
      if (obs !== 6'b0_00_0_0_1) begin
         tests_failed++;
         $display("FAIL reset_idle got=%b exp=%b", obs, 6'b0_00_0_0_1);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; in_valid = 1'b1; in_y = 7'h38;
      step(); in_y = 7'h55;
      tests_run++;
      if (obs !== 6'b1_00_0_0_1) begin
         tests_failed++;
         $display("FAIL b2b_zero got=%b exp=%b", obs, 6'b1_00_0_0_1);
      end
      step(); in_y = 7'h0B;
      tests_run++;
      if (obs !== 6'b1_01_0_0_1) begin
         tests_failed++;
         $display("FAIL b2b_one got=%b exp=%b", obs, 6'b1_01_0_0_1);
      end
      step(); in_valid = 1'b0;
      tests_run++;
      if (obs !== 6'b1_10_0_0_1) begin
         tests_failed++;
         $display("FAIL b2b_two got=%b exp=%b", obs, 6'b1_10_0_0_1);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_drain out_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; in_y = 7'h38;
      step(); in_y = 7'h0B;
      tests_run++;
      if (obs !== 6'b1_00_0_0_0) begin
         tests_failed++;
         $display("FAIL bp_first got=%b exp=%b", obs, 6'b1_00_0_0_0);
      end
      step();
      tests_run++;
      if (obs !== 6'b1_00_0_0_0) begin
         tests_failed++;
         $display("FAIL bp_hold1 got=%b exp=%b", obs, 6'b1_00_0_0_0);
      end
      step();
      tests_run++;
      if (obs !== 6'b1_00_0_0_0) begin
         tests_failed++;
         $display("FAIL bp_hold2 got=%b exp=%b", obs, 6'b1_00_0_0_0);
      end
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (obs !== 6'b1_00_0_0_1) begin
         tests_failed++;
         $display("FAIL bp_release_ready got=%b exp=%b", obs, 6'b1_00_0_0_1);
      end
      step(); in_valid = 1'b0;
      tests_run++;
      if (obs !== 6'b1_10_0_0_1) begin
         tests_failed++;
         $display("FAIL bp_second got=%b exp=%b", obs, 6'b1_10_0_0_1);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_drain out_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_error_stream();
      out_ready = 1'b1; in_valid = 1'b1; in_y = 7'h7F;
      step(); in_y = 7'h00;
      tests_run++;
      if (obs !== 6'b1_11_1_0_1) begin
         tests_failed++;
         $display("FAIL err_7f got=%b exp=%b", obs, 6'b1_11_1_0_1);
      end
      step(); in_y = 7'h38;
      tests_run++;
      if (obs !== 6'b1_11_1_0_1) begin
         tests_failed++;
         $display("FAIL err_00 got=%b exp=%b", obs, 6'b1_11_1_0_1);
      end
      step(); in_y = 7'h12;
      tests_run++;
      if (obs !== 6'b1_00_0_0_1) begin
         tests_failed++;
         $display("FAIL err_38 got=%b exp=%b", obs, 6'b1_00_0_0_1);
      end
      step(); in_valid = 1'b0;
      tests_run++;
      if (obs !== 6'b1_11_1_0_1) begin
         tests_failed++;
         $display("FAIL err_12 got=%b exp=%b", obs, 6'b1_11_1_0_1);
      end
      step();
      tests_run++;
      if ({out_valid, fault, in_ready} !== 3'b001) begin
         tests_failed++;
         $display("FAIL err_nofault got=%b exp=%b", {out_valid, fault, in_ready}, 3'b001);
      end
   endtask

   task automatic test_fault();
      // One invalid word is already counted; a clear in RUN must zero it
      clear_fault = 1'b1;
      step(); clear_fault = 1'b0;
      tests_run++;
      if ({fault, in_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL flt_clear_run got=%b exp=%b", {fault, in_ready}, 2'b01);
      end
      out_ready = 1'b1; in_valid = 1'b1; in_y = 7'h01;
      step(); in_y = 7'h7F;
      tests_run++;
      if (obs !== 6'b1_11_1_0_1) begin
         tests_failed++;
         $display("FAIL flt_bad1 got=%b exp=%b", obs, 6'b1_11_1_0_1);
      end
      step(); in_y = 7'h02;
      tests_run++;
      if (obs !== 6'b1_11_1_0_1) begin
         tests_failed++;
         $display("FAIL flt_bad2 got=%b exp=%b", obs, 6'b1_11_1_0_1);
      end
      step(); in_y = 7'h55;
      tests_run++;
      if (obs !== 6'b1_11_1_1_0) begin
         tests_failed++;
         $display("FAIL flt_bad3_enter got=%b exp=%b", obs, 6'b1_11_1_1_0);
      end
      step();
      tests_run++;
      if (obs !== 6'b0_11_1_1_0) begin
         tests_failed++;
         $display("FAIL flt_drained got=%b exp=%b", obs, 6'b0_11_1_1_0);
      end
      step();
      tests_run++;
      if (obs !== 6'b0_11_1_1_0) begin
         tests_failed++;
         $display("FAIL flt_blocked got=%b exp=%b", obs, 6'b0_11_1_1_0);
      end
      clear_fault = 1'b1;
      step(); clear_fault = 1'b0;
      tests_run++;
      if (obs !== 6'b0_11_1_0_1) begin
         tests_failed++;
         $display("FAIL flt_cleared got=%b exp=%b", obs, 6'b0_11_1_0_1);
      end
      step(); in_valid = 1'b0;
      tests_run++;
      if (obs !== 6'b1_01_0_0_1) begin
         tests_failed++;
         $display("FAIL flt_after_one got=%b exp=%b", obs, 6'b1_01_0_0_1);
      end
      step();
   endtask

   task automatic test_reset_pending();
      out_ready = 1'b1; in_valid = 1'b1; in_y = 7'h7F;
      step(); step(); step();
      out_ready = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (obs !== 6'b1_11_1_1_0) begin
         tests_failed++;
         $display("FAIL rstp_setup got=%b exp=%b", obs, 6'b1_11_1_1_0);
      end
      step();
      tests_run++;
      if (obs !== 6'b1_11_1_1_0) begin
         tests_failed++;
         $display("FAIL rstp_pending got=%b exp=%b", obs, 6'b1_11_1_1_0);
      end
      rst = 1'b1;
      step();
      tests_run++;
      if (obs !== 6'b0_00_0_0_1) begin
         tests_failed++;
         $display("FAIL rstp_after got=%b exp=%b", obs, 6'b0_00_0_0_1);
      end
      rst = 1'b0;
      step();
   endtask

`ifdef GATE_DEC_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; in_y = 7'h55;
      repeat (5) step();
      in_y = 7'h01;
      repeat (2) step();
      in_valid = 1'b0;
      clear_fault = 1'b1;
      step(); clear_fault = 1'b0;
      tests_run++;
      if (cnt_one !== 16'd5) begin
         tests_failed++;
         $display("FAIL stat_one got=%0d exp=5", cnt_one);
      end
      tests_run++;
      if (cnt_err !== 16'd2) begin
         tests_failed++;
         $display("FAIL stat_err got=%0d exp=2", cnt_err);
      end
      tests_run++;
      if (cnt_zero !== 16'd0) begin
         tests_failed++;
         $display("FAIL stat_zero got=%0d exp=0", cnt_zero);
      end
      tests_run++;
      if (cnt_two !== 16'd0) begin
         tests_failed++;
         $display("FAIL stat_two got=%0d exp=0", cnt_two);
      end
      tests_run++;
      if (fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL stat_nofault got=%b exp=0", fault);
      end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_error_stream();
      test_fault();
      test_reset_pending();
`ifdef GATE_DEC_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/gate_vector_decoder.md
# gate_vector_decoder

Receiving end of the gate-vector interface. Accepts 7-bit gate result words, the OR/AND/XOR/XNOR/NAND/NOR/SUM bundle driven by the two-input gate block. Each word is decoded back to the count of asserted gate inputs (0, 1 or 2); words matching no legal pattern are flagged. The block is streaming with valid/ready on both sides, uses one output register stage, and latches a fault state after repeated invalid words.

## Interface
- ERR_LIMIT, 3: consecutive invalid words that trigger FAULT; legal range 1..15.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_y  in  7  gate vector; bit 0 OR, 1 AND, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 SUM (LSB of a+b).
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts the result.
- out_ones  out  2  inputs asserted: 0, 1 or 2; 2'b11 when invalid.
- out_err  out  1  result corresponds to an invalid word.
- fault  out  1  block is in FAULT.
- clear_fault  in  1  single-cycle pulse; leaves FAULT.

## Operation
- Legal codes, in_y[6:0]:
  - 7'h38 decodes to ones=0 (a=0, b=0).
  - 7'h55 decodes to ones=1 (a≠b; the order of a and b is not recoverable).
  - 7'h0B decodes to ones=2 (a=1, b=1).
  - Any other value decodes to ones=2'b11 with err=1.
- A transfer occurs when in_valid && in_ready.
- Output register loads on each transfer and holds until out_valid && out_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready). A full output register with out_ready high accepts a new word in the same cycle (pass-through, no bubble).
- Consecutive-error counter, 4 bits:
  - Increments on each invalid transfer.
  - Clears on each valid transfer.
  - Saturates at 15.
- FSM states:
  - RUN (reset state): when an invalid transfer brings the count to ERR_LIMIT, go to FAULT.
  - FAULT: in_ready=0 and fault=1. A pending output stays valid and still drains. clear_fault goes to RUN and zeroes the error counter.
- clear_fault while in RUN clears only the consecutive-error counter.
- Reset values:
  - out_valid=0, out_ones=0, out_err=0, fault=0.
  - state=RUN, error counter 0, in_ready=1 the cycle after reset.
- Reset during a pending output discards it; out_valid goes 0 on the next edge.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on out_* after edge N, and is consumable from cycle N+1.
- Throughput is 1 word/cycle while out_ready is held high.
- fault rises on the edge that accepts the ERR_LIMIT-th consecutive invalid word. That word's result is still presented with out_err=1. in_ready drops in the same following cycle.
- clear_fault sampled at edge N: fault=0 and in_ready may be 1 from cycle N+1.
- in_ready is combinational from out_valid, out_ready and state only. It never depends on in_valid.

## Configuration
- GATE_DEC_STATS_EN defined: adds outputs cnt_zero, cnt_one, cnt_two, cnt_err (each CNT_W bits).
  - Each counter increments on a transfer of its class.
  - Counters saturate at all-ones.
  - Counters clear on rst only; clear_fault does not clear them.
- GATE_DEC_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package gate_vec_pkg holds:
  - Localparams CODE_ZERO=7'h38, CODE_ONE=7'h55, CODE_TWO=7'h0B.
  - Bit-index constants for the seven gate positions.
  - FSM state enum {RUN, FAULT}.
- One sub-module, gate_code_lookup: pure combinational map from in_y to {ones, err}. It is reused by future checkers.
- The top level holds the handshake, output register, FSM and counters.

## Test plan
- Reset, then in_y=7'h38, 7'h55, 7'h0B back-to-back with out_ready=1 -> out_ones 0, 1, 2 on consecutive cycles, out_err=0, no bubbles.
- Hold out_ready=0 with 2 words offered -> first result holds stable, in_ready=0. Raise out_ready -> second word accepted that same cycle; both results delivered in order.
- Send 7'h7F, 7'h00, 7'h38, 7'h12 -> results err=1, 1, 0, 1; no FAULT, because the counter resets on 7'h38.
- Send 3 consecutive invalid words (ERR_LIMIT=3) -> third result err=1 and fault=1; in_ready=0 until clear_fault. After the pulse, 7'h55 decodes to ones=1.
- Assert rst while out_valid=1 and fault=1 -> next cycle out_valid=0, fault=0, in_ready=1.
- With GATE_DEC_STATS_EN: send 5x 7'h55 and 2x 7'h01 -> cnt_one=5, cnt_err=2, cnt_zero=cnt_two=0.
